alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//   Sequential 8-bit ALU stage directly downstream of the operand mux (mux2x1).
//   Operand a comes from the register file; operand b is the mux output (reg or imm).
//   Single-cycle logic/arith ops plus multi-cycle iterative SLL and MUL.
//   Result and flags are registered and handed to writeback with a start/busy/done handshake.
// PARAMETERS
//   WIDTH  8  data width of operands/result (op encoding below fixed; SLL amount = b[2:0])
// PORTS
//   clk       in   1      clock, all state updates on rising edge
//   rst       in   1      synchronous reset, active-high
//   start     in   1      request; sampled only when accepting (IDLE, or the done cycle)
//   op        in   3      000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLL, 111 MUL
//   a         in   WIDTH  operand A (register file)
//   b         in   WIDTH  operand B (mux2x1 out)
//   busy      out  1      high while a multi-cycle op is in progress
//   done      out  1      one-cycle pulse: result/flags just updated
//   result    out  WIDTH  registered result, held until next completion
//   zero      out  1      result == 0
//   carry     out  1      see flag rules
//   overflow  out  1      signed overflow, ADD/SUB only
// BEHAVIOUR
//   - Reset (rst=1 at an edge): state IDLE; busy, done, result, zero, carry, overflow all 0.
//     Reset mid-operation aborts it: no done, partial result discarded.
//   - States: IDLE, SHIFT, MUL. Operands and op are latched on the accepting edge;
//     a/b/op may change afterwards without effect.
//   - Timing: start high in cycle t (accepted) -> done high in cycle t+L, for exactly one cycle.
//     L=1 for ADD/SUB/AND/OR/XOR/SLT; L=1+k for SLL (k=b[2:0], k=0 gives L=1); L=WIDTH+1 (=9) for MUL.
//   - busy high in cycles t+1..t+L-1 (never for L=1); low in the done cycle.
//   - start while busy: ignored, no queuing.
//   - start in the done cycle: accepted (back-to-back); done/result of the completing op are unaffected.
//   - SHIFT: one left shift per cycle, zero fill, counter k down to 0, then completes.
//   - MUL: shift-add, one multiplier bit per cycle, WIDTH iterations, 2*WIDTH-bit accumulator;
//     result = product[WIDTH-1:0].
//   - SLT: result = {WIDTH-1 zeros, ($signed(a) < $signed(b))}.
//   - Flag rules (all updated only at completion, together with result):
//     zero = (result == 0) for every op.
//     ADD: carry = carry-out of a+b; overflow = signed overflow.
//     SUB: computed as a + ~b + 1; carry = carry-out (1 = no borrow); overflow = signed overflow.
//     SLL: carry = last bit shifted out (0 if k=0); overflow = 0.
//     MUL: carry = (product[2*WIDTH-1:WIDTH] != 0); overflow = 0.
//     AND/OR/XOR/SLT: carry = 0, overflow = 0.
//   - Between completions, result and flags hold their values; done = 0.
// TESTING
//   1. ADD a=8'h7F b=8'h01 -> done at t+1; result=8'h80, overflow=1, carry=0, zero=0.
//   2. SUB a=8'h05 b=8'h05 -> done at t+1; result=8'h00, zero=1, carry=1, overflow=0.
//   3. MUL a=8'd12 b=8'd13 -> busy in t+1..t+8, done at t+9; result=8'h9C, carry=0.
//      MUL a=8'h20 b=8'h10 -> result=8'h00, carry=1, zero=1.
//   4. SLL a=8'h81 b=8'h03 -> done at t+4; result=8'h08, carry=0.
//      SLL a=8'h81 b=8'h01 -> done at t+2; result=8'h02, carry=1.
//   5. start pulses during MUL busy: no effect; MUL completes at t+9.
//      start=1 with ADD in the done cycle: ADD done at t+10.
//   6. rst=1 in cycle t+4 of a MUL: next cycle all outputs 0, no done.
//      A new ADD 3+4 afterwards gives result=8'h07 at t'+1.

Source files
------------

// File: rtl/alu_seq.sv
// Sequential ALU stage: single-cycle logic/arith ops, iterative SLL and shift-add MUL,
// registered result/flags with a start/busy/done handshake.
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpSlt = 3'b101;
  localparam logic [2:0] OpSll = 3'b110;
  localparam logic [2:0] OpMul = 3'b111;

  typedef enum logic [1:0] {StIdle, StShift, StMul} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  // Shift register for SLL, multiplier for MUL.
  logic [WIDTH-1:0]     work_q, work_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 zero_q, zero_d;
  logic                 carry_q, carry_d;
  logic                 ovf_q, ovf_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     bx;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   acc_sum;
  logic                 complete;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    work_d   = work_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    complete = 1'b0;

    // SUB is a + ~b + 1, so carry-out means "no borrow".
    bx      = (op == OpSub) ? ~b : b;
    sum     = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, (op == OpSub)};
    acc_sum = acc_q + (work_q[0] ? mcand_q : '0);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          unique case (op)
            OpAdd, OpSub: begin
              result_d = sum[WIDTH-1:0];
              carry_d  = sum[WIDTH];
              ovf_d    = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
              complete = 1'b1;
            end
            OpAnd, OpOr, OpXor, OpSlt: begin
              unique case (op)
                OpAnd:   result_d = a & b;
                OpOr:    result_d = a | b;
                OpXor:   result_d = a ^ b;
                default: result_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
              endcase
              carry_d  = 1'b0;
              ovf_d    = 1'b0;
              complete = 1'b1;
            end
            OpSll: begin
              if (b[2:0] == 3'd0) begin
                result_d = a;
                carry_d  = 1'b0;
                ovf_d    = 1'b0;
                complete = 1'b1;
              end else begin
                work_d  = a;
                cnt_d   = CW'(b[2:0]);
                state_d = StShift;
              end
            end
            OpMul: begin
              acc_d   = '0;
              mcand_d = {{WIDTH{1'b0}}, a};
              work_d  = b;
              cnt_d   = CW'(WIDTH);
              state_d = StMul;
            end
            default: ;
          endcase
        end
      end
      StShift: begin
        work_d = work_q << 1;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          result_d = work_q << 1;
          carry_d  = work_q[WIDTH-1];
          ovf_d    = 1'b0;
          complete = 1'b1;
          state_d  = StIdle;
        end
      end
      StMul: begin
        acc_d   = acc_sum;
        mcand_d = mcand_q << 1;
        work_d  = work_q >> 1;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          result_d = acc_sum[WIDTH-1:0];
          carry_d  = |acc_sum[2*WIDTH-1:WIDTH];
          ovf_d    = 1'b0;
          complete = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    done_d = complete;
    zero_d = complete ? (result_d == '0) : zero_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      work_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      work_q   <= work_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign result   = result_q;
  assign zero     = zero_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq: latency, handshake, flags, back-to-back and reset abort.
module tb_alu_seq;

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpSlt = 3'b101;
  localparam logic [2:0] OpSll = 3'b110;
  localparam logic [2:0] OpMul = 3'b111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] op = 3'b000;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       busy, done, zero, carry, overflow;
  logic [7:0] result;

  int checks = 0;
  int failures = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .zero     (zero),
    .carry    (carry),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one op, scramble the inputs after acceptance, then check busy/done timing and outputs.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [7:0] x,
                        input logic [7:0] y, input int lat, input logic [7:0] r,
                        input logic z, input logic c, input logic v);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = ~o; a = ~x; b = ~y;
    for (int i = 1; i < lat; i++) begin
      check({tag, "_busy"}, {15'd0, busy}, 16'd1);
      check({tag, "_early_done"}, {15'd0, done}, 16'd0);
      @(negedge clk);
    end
    check({tag, "_done"}, {15'd0, done}, 16'd1);
    check({tag, "_busy_at_done"}, {15'd0, busy}, 16'd0);
    check({tag, "_result"}, {8'd0, result}, {8'd0, r});
    check({tag, "_flags"}, {13'd0, zero, carry, overflow}, {13'd0, z, c, v});
    @(negedge clk);
    check({tag, "_done_pulse"}, {15'd0, done}, 16'd0);
    check({tag, "_hold"}, {8'd0, result}, {8'd0, r});
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_outputs", {10'd0, busy, done, zero, carry, overflow, |result}, 16'd0);
    rst = 1'b0;

    //      tag        op     a      b      L  result z     c     v
    run_op("add_ovf",  OpAdd, 8'h7F, 8'h01, 1, 8'h80, 1'b0, 1'b0, 1'b1);
    run_op("add_cy",   OpAdd, 8'hFF, 8'h01, 1, 8'h00, 1'b1, 1'b1, 1'b0);
    run_op("sub_eq",   OpSub, 8'h05, 8'h05, 1, 8'h00, 1'b1, 1'b1, 1'b0);
    run_op("sub_brw",  OpSub, 8'h03, 8'h05, 1, 8'hFE, 1'b0, 1'b0, 1'b0);
    run_op("sub_ovf",  OpSub, 8'h80, 8'h01, 1, 8'h7F, 1'b0, 1'b1, 1'b1);
    run_op("and",      OpAnd, 8'hF0, 8'h3C, 1, 8'h30, 1'b0, 1'b0, 1'b0);
    run_op("or",       OpOr,  8'hF0, 8'h0F, 1, 8'hFF, 1'b0, 1'b0, 1'b0);
    run_op("xor",      OpXor, 8'h5A, 8'h5A, 1, 8'h00, 1'b1, 1'b0, 1'b0);
    run_op("slt_neg",  OpSlt, 8'h80, 8'h01, 1, 8'h01, 1'b0, 1'b0, 1'b0);
    run_op("slt_no",   OpSlt, 8'h05, 8'h03, 1, 8'h00, 1'b1, 1'b0, 1'b0);
    run_op("sll3",     OpSll, 8'h81, 8'h03, 4, 8'h08, 1'b0, 1'b0, 1'b0);
    run_op("sll1",     OpSll, 8'h81, 8'h01, 2, 8'h02, 1'b0, 1'b1, 1'b0);
    run_op("sll0",     OpSll, 8'h81, 8'h08, 1, 8'h81, 1'b0, 1'b0, 1'b0);
    run_op("mul",      OpMul, 8'd12, 8'd13, 9, 8'h9C, 1'b0, 1'b0, 1'b0);
    run_op("mul_hi",   OpMul, 8'h20, 8'h10, 9, 8'h00, 1'b1, 1'b1, 1'b0);

    // start pulses during MUL are ignored; ADD issued in the done cycle runs back-to-back.
    @(negedge clk);
    start = 1'b1; op = OpMul; a = 8'd12; b = 8'd13;
    @(negedge clk);
    for (int i = 1; i < 9; i++) begin
      start = i[0]; op = OpAdd; a = 8'h11; b = 8'h22;
      check("mul_ign_busy", {15'd0, busy}, 16'd1);
      check("mul_ign_done", {15'd0, done}, 16'd0);
      @(negedge clk);
    end
    check("mul_ign_final_done", {15'd0, done}, 16'd1);
    check("mul_ign_result", {8'd0, result}, 16'h009C);
    start = 1'b1; op = OpAdd; a = 8'h01; b = 8'h02;
    @(negedge clk);
    start = 1'b0;
    check("b2b_done", {15'd0, done}, 16'd1);
    check("b2b_busy", {15'd0, busy}, 16'd0);
    check("b2b_result", {8'd0, result}, 16'h0003);

    // Reset in cycle t+4 of a MUL aborts it.
    @(negedge clk);
    start = 1'b1; op = OpMul; a = 8'd12; b = 8'd13;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_abort_outputs", {10'd0, busy, done, zero, carry, overflow, |result}, 16'd0);
    for (int i = 0; i < 8; i++) begin
      check("rst_abort_no_done", {15'd0, done}, 16'd0);
      @(negedge clk);
    end
    run_op("add_after_rst", OpAdd, 8'd3, 8'd4, 1, 8'h07, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
